// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - Iterative SHA-256 message schedule generator, 16-word sliding window
module sha256_msg_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         block_valid,
    input  logic [511:0] block,
    output logic         block_ready,
    input  logic         abort,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w,
    output logic [5:0]   w_index,
    output logic         w_last,
    output logic         busy
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_t      state_q, state_d;
    logic [5:0]  index_q, index_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic        ready_en_q, ready_en_d;
    logic [31:0] next_word;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        win_d      = win_q;
        ready_en_d = 1'b1;
        next_word  = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

        case (state_q)
            S_IDLE: begin
                // abort outranks an offered block, so nothing is captured
                if (!abort && block_valid && ready_en_q) begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = block[511 - 32*i -: 32];
                    end
                    index_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    index_d = '0;
                    state_d = S_IDLE;
                end else if (w_ready) begin
                    if (index_q == LAST_IDX) begin
                        index_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        for (int i = 0; i < 15; i++) begin
                            win_d[i] = win_q[i+1];
                        end
                        win_d[15] = next_word;
                        index_d   = index_q + 6'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            ready_en_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            ready_en_q <= ready_en_d;
            win_q      <= win_d;
        end
    end

    // every output comes straight from state flops; w_ready never reaches them combinationally
    assign block_ready = (state_q == S_IDLE) && ready_en_q;
    assign w_valid     = (state_q == S_RUN);
    assign busy        = (state_q == S_RUN);
    assign w           = win_q[0];
    assign w_index     = index_q;
    assign w_last      = (state_q == S_RUN) && (index_q == LAST_IDX);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - Directed/table-driven bench for sha256_msg_schedule
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         reset;
    logic         block_valid;
    logic [511:0] block;
    logic         block_ready;
    logic         abort;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w;
    logic [5:0]   w_index;
    logic         w_last;
    logic         busy;

    logic         block_valid16;
    logic [511:0] block16;
    logic         block_ready16;
    logic         abort16;
    logic         w_valid16;
    logic         w_ready16;
    logic [31:0]  w16;
    logic [5:0]   w_index16;
    logic         w_last16;
    logic         busy16;

    sha256_msg_schedule #(.ROUNDS(64)) dut (
        .clk(clk), .reset(reset), .block_valid(block_valid), .block(block),
        .block_ready(block_ready), .abort(abort), .w_valid(w_valid), .w_ready(w_ready),
        .w(w), .w_index(w_index), .w_last(w_last), .busy(busy)
    );

    sha256_msg_schedule #(.ROUNDS(16)) dut16 (
        .clk(clk), .reset(reset), .block_valid(block_valid16), .block(block16),
        .block_ready(block_ready16), .abort(abort16), .w_valid(w_valid16), .w_ready(w_ready16),
        .w(w16), .w_index(w_index16), .w_last(w_last16), .busy(busy16)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [9];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_w   [64];
    logic [31:0] obs     [64];
    logic [31:0] obs_abc [64];
    logic [31:0] obs_seq [64];
    logic [511:0] blk_abc, blk_seq, blk_tmp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic model(input logic [511:0] b);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
        return b;
    endfunction

    task automatic send_block(input logic [511:0] b);
        int cyc = 0;
        block       = b;
        block_valid = 1'b1;
        while (!block_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("send_timeout", 32'(block_ready), 32'd1);
        @(posedge clk);
        #1;
        block_valid = 1'b0;
    endtask

    task automatic consume(input bit rnd, input int n, input bit check_end);
        int          got = 0;
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] pw = '0;
        logic [5:0]  pi = '0;
        while (got < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (!w_valid) begin
                chk("w_valid_run", 32'(w_valid), 32'd1);
                break;
            end
            if (stalled) begin
                chk("stall_w", w, pw);
                chk("stall_idx", 32'(w_index), 32'(pi));
            end
            chk("w_index", 32'(w_index), 32'(got));
            chk("w", w, exp_w[got]);
            chk("w_last", 32'(w_last), (got == 63) ? 32'd1 : 32'd0);
            chk("block_ready_run", 32'(block_ready), 32'd0);
            chk("busy_run", 32'(busy), 32'd1);
            obs[got] = w;
            w_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled  = !w_ready;
            pw       = w;
            pi       = w_index;
            if (w_ready) got++;
        end
        chk("handshakes", 32'(got), 32'(n));
        if (check_end) begin
            @(negedge clk);
            w_ready = 1'b0;
            chk("w_valid_end", 32'(w_valid), 32'd0);
            chk("block_ready_end", 32'(block_ready), 32'd1);
            chk("busy_end", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        blk_abc = '0;
        blk_abc[511:480] = 32'h61626380;
        blk_abc[31:0]    = 32'h00000018;
        for (int i = 0; i < 16; i++) blk_seq[511 - 32*i -: 32] = 32'(i + 1);

        vecs[0] = '{0, 0,  32'h61626380};
        vecs[1] = '{0, 1,  32'h00000000};
        vecs[2] = '{0, 14, 32'h00000000};
        vecs[3] = '{0, 15, 32'h00000018};
        vecs[4] = '{0, 16, 32'h61626380};
        vecs[5] = '{0, 17, 32'h000F0000};
        vecs[6] = '{1, 0,  32'h00000001};
        vecs[7] = '{1, 15, 32'h00000010};
        vecs[8] = '{1, 16, 32'h0406E00B};

        reset = 1'b1; block_valid = 1'b0; block = '0; abort = 1'b0; w_ready = 1'b0;
        block_valid16 = 1'b0; block16 = '0; abort16 = 1'b0; w_ready16 = 1'b0;

        #1;
        chk("rst_block_ready", 32'(block_ready), 32'd0);
        chk("rst_w_valid", 32'(w_valid), 32'd0);
        chk("rst_w_last", 32'(w_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_block_ready_pre", 32'(block_ready), 32'd0);
        @(negedge clk);
        chk("rel_block_ready", 32'(block_ready), 32'd1);

        // abc, full-rate consumer
        model(blk_abc);
        send_block(blk_abc);
        consume(1'b0, 64, 1'b1);

        // abc, random backpressure
        send_block(blk_abc);
        consume(1'b1, 64, 1'b1);
        for (int i = 0; i < 64; i++) obs_abc[i] = obs[i];

        // back-to-back, block_valid held high through the first block
        blk_tmp = rand_block();
        model(blk_tmp);
        block = blk_tmp;
        block_valid = 1'b1;
        @(posedge clk);
        #1;
        block = blk_seq;
        consume(1'b0, 64, 1'b1);
        @(posedge clk);
        #1;
        block_valid = 1'b0;
        model(blk_seq);
        consume(1'b0, 64, 1'b1);
        for (int i = 0; i < 64; i++) obs_seq[i] = obs[i];

        for (int v = 0; v < 9; v++) begin
            chk($sformatf("vec%0d", v),
                (vecs[v].sel == 0) ? obs_abc[vecs[v].idx] : obs_seq[vecs[v].idx], vecs[v].exp);
        end

        // abort at index 20 with a simultaneous handshake
        blk_tmp = rand_block();
        model(blk_tmp);
        send_block(blk_tmp);
        consume(1'b0, 20, 1'b0);
        @(negedge clk);
        chk("abort_idx", 32'(w_index), 32'd20);
        abort = 1'b1;
        w_ready = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        w_ready = 1'b0;
        @(negedge clk);
        chk("abort_w_valid", 32'(w_valid), 32'd0);
        chk("abort_block_ready", 32'(block_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        abort = 1'b1;
        block = blk_seq;
        block_valid = 1'b1;
        @(negedge clk);
        chk("abort_idle_nocap", 32'(w_valid), 32'd0);
        abort = 1'b0;
        block_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_quiet", 32'(w_valid), 32'd0);
        model(blk_seq);
        send_block(blk_seq);
        consume(1'b0, 64, 1'b1);

        // asynchronous reset mid-block at index 37
        blk_tmp = rand_block();
        model(blk_tmp);
        send_block(blk_tmp);
        consume(1'b0, 37, 1'b0);
        @(negedge clk);
        chk("rst_mid_idx", 32'(w_index), 32'd37);
        w_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_w_valid", 32'(w_valid), 32'd0);
        chk("rstmid_w_last", 32'(w_last), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_block_ready", 32'(block_ready), 32'd0);
        chk("rstmid_w_index", 32'(w_index), 32'd0);
        chk("rstmid_w", w, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_ready_after", 32'(block_ready), 32'd1);
        model(blk_abc);
        send_block(blk_abc);
        consume(1'b0, 64, 1'b1);

        // ROUNDS = 16 instance: message words verbatim, last at 15
        blk_tmp = rand_block();
        block16 = blk_tmp;
        block_valid16 = 1'b1;
        @(posedge clk);
        #1;
        block_valid16 = 1'b0;
        w_ready16 = 1'b1;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            chk("r16_valid", 32'(w_valid16), 32'd1);
            chk("r16_idx", 32'(w_index16), 32'(t));
            chk("r16_w", w16, blk_tmp[511 - 32*t -: 32]);
            chk("r16_last", 32'(w_last16), (t == 15) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        w_ready16 = 1'b0;
        chk("r16_end_valid", 32'(w_valid16), 32'd0);
        chk("r16_end_ready", 32'(block_ready16), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
